// File: rtl/bcd_counter4.sv
// Four-digit BCD up/down counter with prescaled count tick, parallel load and wrap flag.
// Define BCD_COUNTER4_SATURATE_EN to stop at 9999/0000 instead of wrapping (wrap then flags a limit hit).
module bcd_counter4 #(
  parameter int unsigned CLK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        up,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [3:0]  x0,
  output logic [3:0]  x1,
  output logic [3:0]  x2,
  output logic [3:0]  x3,
  output logic        wrap
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

  logic [PW-1:0]   pcnt;
  logic            tick;
  logic [3:0][3:0] dig;
  logic [3:0][3:0] step;
  logic [3:0][3:0] ldig;
  logic            limit;

  assign tick = en && (pcnt == PMAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
    end else if (load) begin
      pcnt <= '0;
    end else if (en) begin
      if (tick) pcnt <= '0;
      else      pcnt <= pcnt + PW'(1);
    end
  end

  // Ripple the carry/borrow from x0 upward; a carry out of x3 marks the 9999/0000 boundary.
  always_comb begin
    logic carry;
    step  = dig;
    carry = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (up) begin
          if (dig[i] == 4'd9) begin
            step[i] = 4'd0;
          end else begin
            step[i] = dig[i] + 4'd1;
            carry   = 1'b0;
          end
        end else begin
          if (dig[i] == 4'd0) begin
            step[i] = 4'd9;
          end else begin
            step[i] = dig[i] - 4'd1;
            carry   = 1'b0;
          end
        end
      end
    end
    limit = carry;
  end

  always_comb begin
    ldig = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      ldig[i] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dig  <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      dig  <= ldig;
      wrap <= 1'b0;
    end else if (tick) begin
`ifdef BCD_COUNTER4_SATURATE_EN
      if (!limit) dig <= step;
`else
      dig <= step;
`endif
      wrap <= limit;
    end else begin
      wrap <= 1'b0;
    end
  end

  assign x0 = dig[0];
  assign x1 = dig[1];
  assign x2 = dig[2];
  assign x3 = dig[3];

endmodule

// File: tb/tb_bcd_counter4.sv
// Self-checking bench for bcd_counter4 (CLK_DIV=4): directed steps plus random traffic
// compared against an integer-valued reference model of the counter.
module tb_bcd_counter4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        up = 1'b1;
  logic        load = 1'b0;
  logic [15:0] load_val = '0;
  logic [3:0]  x0, x1, x2, x3;
  logic        wrap;

  int vectors = 0;
  int miscompares = 0;

  // reference state: counter value as a plain integer, prescaler phase, wrap flag
  int mv = 0;
  int mp = 0;
  bit mw = 1'b0;

  bcd_counter4 #(.CLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int clamp_val(input logic [15:0] lv);
    int r = 0;
    int w = 1;
    for (int i = 0; i < 4; i++) begin
      int n = int'(lv[4*i +: 4]);
      if (n > 9) n = 9;
      r = r + n * w;
      w = w * 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one clock, update the model from the inputs in force, compare all outputs
  task automatic cyc();
    int nv = mv;
    int np = mp;
    bit nw = 1'b0;
    if (rst) begin
      nv = 0; np = 0;
    end else if (load) begin
      nv = clamp_val(load_val); np = 0;
    end else if (en) begin
      if (mp == 3) begin
        np = 0;
        if (up) begin
          if (mv == 9999) begin
            nw = 1'b1;
`ifdef BCD_COUNTER4_SATURATE_EN
            nv = 9999;
`else
            nv = 0;
`endif
          end else nv = mv + 1;
        end else begin
          if (mv == 0) begin
            nw = 1'b1;
`ifdef BCD_COUNTER4_SATURATE_EN
            nv = 0;
`else
            nv = 9999;
`endif
          end else nv = mv - 1;
        end
      end else np = mp + 1;
    end
    @(posedge clk);
    #1;
    mv = nv; mp = np; mw = nw;
    chk("digits", {x3, x2, x1, x0}, to_bcd(mv));
    chk("wrap", {15'd0, wrap}, {15'd0, mw});
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_val = v;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    // reset
    repeat (2) cyc();
    chk("reset_digits", {x3, x2, x1, x0}, 16'h0000);
    chk("reset_wrap", {15'd0, wrap}, 16'h0000);

    // 40 enabled cycles count to 10
    rst = 1'b0; en = 1'b1; up = 1'b1;
    repeat (40) cyc();
    chk("count40", {x3, x2, x1, x0}, 16'h0010);

    // wrap upward
    do_load(16'h9998);
    repeat (4) cyc();
    chk("up_9999", {x3, x2, x1, x0}, 16'h9999);
    repeat (4) cyc();
`ifndef BCD_COUNTER4_SATURATE_EN
    chk("up_wrap_0000", {x3, x2, x1, x0}, 16'h0000);
`endif
    chk("up_wrap_flag", {15'd0, wrap}, 16'h0001);
    cyc();
    chk("up_wrap_drop", {15'd0, wrap}, 16'h0000);
    repeat (3) cyc();
`ifndef BCD_COUNTER4_SATURATE_EN
    chk("up_0001", {x3, x2, x1, x0}, 16'h0001);
`endif

    // borrow and wrap downward
    up = 1'b0;
    do_load(16'h1000);
    repeat (4) cyc();
    chk("down_0999", {x3, x2, x1, x0}, 16'h0999);
    do_load(16'h0000);
    repeat (4) cyc();
`ifndef BCD_COUNTER4_SATURATE_EN
    chk("down_wrap_9999", {x3, x2, x1, x0}, 16'h9999);
`else
    chk("down_sat_0000", {x3, x2, x1, x0}, 16'h0000);
`endif
    chk("down_wrap_flag", {15'd0, wrap}, 16'h0001);

    // clamped load, then load colliding with a tick
    en = 1'b0;
    do_load(16'hAF3C);
    chk("load_clamp", {x3, x2, x1, x0}, 16'h9939);
    en = 1'b1; up = 1'b1;
    repeat (3) cyc();
    do_load(16'h1234);
    chk("load_beats_tick", {x3, x2, x1, x0}, 16'h1234);
    repeat (4) cyc();
    chk("after_collide", {x3, x2, x1, x0}, 16'h1235);

    // enable pause freezes the prescaler
    do_load(16'h0000);
    repeat (2) cyc();
    en = 1'b0;
    repeat (10) cyc();
    en = 1'b1;
    cyc();
    chk("pause_no_tick", {x3, x2, x1, x0}, 16'h0000);
    cyc();
    chk("pause_tick", {x3, x2, x1, x0}, 16'h0001);

    // reset mid-count
    do_load(16'h0573);
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    chk("rst_mid", {x3, x2, x1, x0}, 16'h0000);
    rst = 1'b0;

`ifdef BCD_COUNTER4_SATURATE_EN
    do_load(16'h9999);
    repeat (4) cyc();
    chk("sat_up_hold", {x3, x2, x1, x0}, 16'h9999);
    chk("sat_up_flag", {15'd0, wrap}, 16'h0001);
    up = 1'b0;
    do_load(16'h0000);
    repeat (4) cyc();
    chk("sat_dn_hold", {x3, x2, x1, x0}, 16'h0000);
    chk("sat_dn_flag", {15'd0, wrap}, 16'h0001);
`endif

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 299) == 0);
      load     = ($urandom_range(0, 24) == 0);
      en       = ($urandom_range(0, 7) != 0);
      up       = ($urandom_range(0, 3) != 0) ? up : ~up;
      load_val = 16'($urandom());
      if ($urandom_range(0, 1) == 1) load_val = to_bcd(($urandom_range(0, 1) == 1) ? 9999 : 0) ^ 16'($urandom_range(0, 1));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_counter4.md
# bcd_counter4

Four-digit BCD up/down counter that generates the digit values driven into the BCD-to-seven-segment display stage. Counts once per prescaled tick, supports parallel load, and flags wrap-around. Outputs `x0`..`x3` connect directly, digit for digit, to the display decoder inputs of the same names.

## Interface
Parameters:
- `CLK_DIV`, 50000000: clock cycles per count tick; legal range 1..2^26; prescaler width is `$clog2(CLK_DIV)` (minimum 1).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  count enable; prescaler and counter hold while low.
- `up`  in  1  direction: 1 increments, 0 decrements.
- `load`  in  1  parallel load strobe.
- `load_val`  in  16  load value, digits {d3,d2,d1,d0}, [3:0] = d0.
- `x0`  out  4  least-significant BCD digit.
- `x1`  out  4  BCD digit 1.
- `x2`  out  4  BCD digit 2.
- `x3`  out  4  most-significant BCD digit.
- `wrap`  out  1  one-cycle pulse on 9999→0000 or 0000→9999.

## Operation
- Prescaler `pcnt` counts 0..CLK_DIV-1 while `en`=1. `tick` is asserted in the cycle where `pcnt`==CLK_DIV-1 and `en`=1; `pcnt` returns to 0 on that cycle. With CLK_DIV=1, `tick` equals `en`.
- On `tick`, with `up`=1: `x0` increments. A digit at 9 becomes 0 and carries into the next digit. With `up`=0: `x0` decrements. A digit at 0 becomes 9 and borrows from the next digit.
- Wrap: increment from 9999 produces 0000; decrement from 0000 produces 9999. `wrap` is high for exactly the cycle after the wrapping tick, aligned with the new digit values.
- Load: when `load`=1, digits take `load_val` and `pcnt` clears to 0. Any nibble greater than 9 is loaded as 9. `wrap`=0.
- Priority: `rst` > `load` > `tick`. A tick coinciding with `load` is discarded.
- `up` is sampled only on tick cycles. Changing `up` between ticks has no other effect.
- Digits always hold values 0..9; the counter never reaches a non-BCD state.

## Timing
- Reset values: `x0`..`x3` = 0, `wrap` = 0, `pcnt` = 0.
- All outputs are registered. Digits update one cycle after the tick or load cycle.
- Reset asserted mid-count clears everything on the next edge. Counting resumes CLK_DIV enabled cycles after `rst` deasserts.
- Deasserting `en` freezes `pcnt`. Reasserting `en` resumes from the frozen value, so no partial tick is lost or repeated.

## Configuration
- `BCD_COUNTER4_SATURATE_EN` defined: the counter stops at 9999 when counting up and at 0000 when counting down. A tick at the limit leaves the digits unchanged and asserts `wrap` for one cycle as a limit-hit flag.
- Not defined: wrap-around behaviour as described in Operation.

## Test plan
Bench uses CLK_DIV=4.
- Reset then `en`=1, `up`=1 for 40 cycles → digits read 0010; each change is spaced exactly 4 cycles apart.
- Load 0x9998, then `en`=1, `up`=1 → 9999, then 0000 with `wrap` high for one cycle, then 0001.
- Load 0x1000, then `up`=0 for one tick → 0999. Load 0x0000 and decrement → 9999 with `wrap`=1.
- Load 0xAF3C → digits 9,9,3,9 (x3..x0 = 9939). Assert `load` and a tick in the same cycle → load value wins and the tick is dropped.
- Set `en`=0 after 2 prescaler counts, hold 10 cycles, then `en`=1 → the next tick arrives after 2 more cycles. Assert `rst` mid-count at 0573 → all outputs 0 on the next edge.
- With `BCD_COUNTER4_SATURATE_EN` defined: load 0x9999 and tick up → digits stay 9999 and `wrap` pulses. Load 0x0000 and tick down → digits stay 0000.
